// File: rtl/vga_timing_gen.sv
// VGA display timing generator: scans the frame, hands (row, column) to the sprite
// generators, and aligns, blanks and drives the returned intensity alongside the syncs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_DLY  = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] pixel_row,
  output logic [11:0] pixel_column,
  input  logic [3:0]  sprite_pix,
  output logic        frame_tick,
  output logic        video_on,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] C_HA    = 12'(H_ACTIVE);
  localparam logic [11:0] C_HS0   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] C_HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] C_HLAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] C_VA    = 12'(V_ACTIVE);
  localparam logic [11:0] C_VS0   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] C_VS1   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] C_VLAST = 12'(V_TOTAL - 1);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } ctl_t;

  logic [11:0] r_row, r_col;
  ctl_t        w_dec, w_dly;
  logic        r_von, r_hs, r_vs, r_tick;
  logic [3:0]  r_pix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (r_col == C_HLAST) begin
      r_col <= '0;
      r_row <= (r_row == C_VLAST) ? 12'd0 : r_row + 12'd1;
    end else begin
      r_col <= r_col + 12'd1;
    end
  end

  always_comb begin
    w_dec     = '0;
    w_dec.vis = (r_col < C_HA) && (r_row < C_VA);
    w_dec.hs  = (r_col >= C_HS0) && (r_col < C_HS1);
    w_dec.vs  = (r_row >= C_VS0) && (r_row < C_VS1);
  end

  // Control bits wait PIX_DLY clocks so they meet a registered sprite source's pixel.
  generate
    if (PIX_DLY == 0) begin : g_nodly
      assign w_dly = w_dec;
    end else begin : g_dly
      ctl_t r_pipe [PIX_DLY];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIX_DLY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_dec;
          for (int i = 1; i < PIX_DLY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_dly = r_pipe[PIX_DLY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_von  <= 1'b0;
      r_hs   <= ~SYNC_POL;
      r_vs   <= ~SYNC_POL;
      r_pix  <= 4'h0;
      r_tick <= 1'b0;
    end else begin
      r_von  <= w_dly.vis;
      r_hs   <= w_dly.hs ? SYNC_POL : ~SYNC_POL;
      r_vs   <= w_dly.vs ? SYNC_POL : ~SYNC_POL;
      r_pix  <= w_dly.vis ? sprite_pix : 4'h0;
      r_tick <= (r_row == C_VA) && (r_col == 12'd0);
    end
  end

  assign pixel_row    = r_row;
  assign pixel_column = r_col;
  assign frame_tick   = r_tick;
  assign video_on     = r_von;
  assign vga_hsync    = r_hs;
  assign vga_vsync    = r_vs;
  assign vga_r        = r_pix;
  assign vga_g        = r_pix;
  assign vga_b        = r_pix;

endmodule
